ds18b20_responder: RTL
======================

DS18B20_RESPONDER -- requirements
Module: ds18b20_responder

Interface
REQ-001 SHALL have parameter CLKS_PER_US, default 50: clk cycles per microsecond; all slot timings derive from it.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-004 SHALL have port dq_in  input  1  1-Wire bus level as seen by the responder (pulled-up, open-drain).
REQ-005 SHALL have port dq_pull_low  output  1  1 = drive bus low; 0 = release bus.
REQ-006 SHALL have port temp_in  input  16  signed temperature in 1/16 degC units, two's complement.
REQ-007 SHALL have port conv_start  output  1  one-cycle pulse when a Convert T (0x44) command completes reception.
REQ-008 SHALL have port cmd_valid  output  1  one-cycle pulse when any command byte (ROM or function) completes reception.
REQ-009 SHALL have port cmd_byte  output  8  last received command byte; valid while cmd_valid is high and held after it.

Function
REQ-010 SHALL pass dq_in through a 2-flop synchronizer; all edge detection uses the synchronized level.
REQ-011 SHALL treat a bus-low interval of at least 480 us as a bus reset in every state, aborting any transfer in progress.
REQ-012 SHALL wait 30 us after the bus releases from a bus reset, then drive dq_pull_low high for 120 us (presence pulse), then release it.
REQ-013 SHALL use states IDLE, PRES_WAIT, PRES_DRIVE, ROM_RX, FUNC_RX, TX, DONE; presence end -> ROM_RX.
REQ-014 SHALL receive bits LSB-first: a falling edge starts a slot; the bus is sampled 30 us after the falling edge; 8 bits form one byte.
REQ-015 SHALL, in ROM_RX: on 0xCC (Skip ROM) go to FUNC_RX; on any other byte go to DONE.
REQ-016 SHALL, in FUNC_RX: on 0x44 latch temp_in into scratchpad bytes 0-1, pulse conv_start, go to DONE; on 0xBE go to TX; on any other byte go to DONE.
REQ-017 SHALL transmit in TX, LSB-first, 9 bytes: T_LSB, T_MSB, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, byte 8 (REQ-025/026).
REQ-018 SHALL, per read slot, on the falling edge drive dq_pull_low high for 30 us when the bit is 0, and leave it low when the bit is 1.
REQ-019 SHALL go to DONE after the 72nd bit; a bus reset before that aborts the transmission cleanly.
REQ-020 SHALL ignore all slots in DONE and IDLE; only a bus reset leaves them.
REQ-021 SHALL never drive dq_pull_low outside PRES_DRIVE and TX 0-bit windows.
REQ-022 SHALL ignore a falling edge that occurs while the responder is itself driving the bus.

Reset
REQ-023 SHALL set, on rst_n low: state IDLE, dq_pull_low 0, conv_start 0, cmd_valid 0, cmd_byte 0x00, scratchpad temperature 0x0550 (85 degC power-on value), bit/byte counters 0.
REQ-024 SHALL release dq_pull_low within 0 cycles of rst_n assertion (asynchronous), including mid-presence or mid-slot.

Configuration
REQ-025 SHALL, with DS18B20_CRC_EN defined, send as byte 8 the Dallas CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00) over bytes 0-7, computed serially as bits shift out.
REQ-026 SHALL, without DS18B20_CRC_EN, send byte 8 as 0x00 and contain no CRC logic.

Verification
REQ-027 SHALL cover: bus low 500 us then release -> dq_pull_low rises 30 us (+-2 cycles) later, lasts 120 us.
REQ-028 SHALL cover: reset, 0xCC, 0xBE, 72 read slots, no prior convert -> bytes 50 05 4B 46 7F FF 0C 10 1C (CRC_EN) / ...10 00 (no CRC_EN).
REQ-029 SHALL cover: temp_in=0x0191, reset, 0xCC, 0x44 -> conv_start one pulse, cmd_valid twice (cmd_byte 0xCC then 0x44); following read returns T_LSB 0x91, T_MSB 0x01.
REQ-030 SHALL cover: reset, ROM byte 0x33 -> cmd_valid with 0x33, subsequent slots produce no dq_pull_low activity until next bus reset.
REQ-031 SHALL cover: bus reset asserted during bit 20 of TX -> drive released at slot end, new presence pulse issued, next read restarts from byte 0.
REQ-032 SHALL cover: rst_n pulled low during PRES_DRIVE -> dq_pull_low 0 immediately, state IDLE, scratchpad temperature 0x0550.

Source files
------------

// File: rtl/ds18b20_responder.sv
// DS18B20 1-Wire slave: bus reset/presence, Skip ROM, Convert T, Read Scratchpad (CRC byte via DS18B20_CRC_EN).
// Latency: presence begins 30 us after bus release; a read bit drives for 30 us from its falling edge.
// Backpressure: none; the bus master owns slot timing, and a >=480 us low always aborts and re-presents.
module ds18b20_responder #(
    parameter int CLKS_PER_US = 50
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dq_in,
    output logic        dq_pull_low,
    input  logic [15:0] temp_in,
    output logic        conv_start,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte
);
    localparam int RST_CYC  = 480 * CLKS_PER_US;
    localparam int T30_CYC  = 30 * CLKS_PER_US;
    localparam int T120_CYC = 120 * CLKS_PER_US;
    // Cycles between the real bus edge and the registered edge-detect (2 sync flops + prev flop).
    localparam int SYNC_LAT = 3;
    localparam int TW       = $clog2(RST_CYC + 1);

    localparam logic [TW-1:0] RST_LIM  = TW'(RST_CYC);
    localparam logic [TW-1:0] T30_END  = TW'(T30_CYC - SYNC_LAT - 1);
    localparam logic [TW-1:0] T120_END = TW'(T120_CYC - 1);

    typedef enum logic [2:0] {
        IDLE, PRES_WAIT, PRES_DRIVE, ROM_RX, FUNC_RX, TX, DONE
    } state_t;

    state_t         state_q, state_d;
    logic           dq_s1_q, dq_s2_q, dq_prev_q;
    logic [TW-1:0]  low_cnt_q, low_cnt_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic           slot_act_q, slot_act_d;
    logic           drive_q, drive_d;
    logic [7:0]     shift_q, shift_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [3:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]    temp_q, temp_d;
    logic [7:0]     cmd_byte_q, cmd_byte_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           conv_start_q, conv_start_d;

    logic           fall, rise, bus_rst, slot_end, tx_bit;
    logic [7:0]     rx_byte, tx_byte, crc_byte;

`ifdef DS18B20_CRC_EN
    logic [7:0]     crc_q, crc_d, crc_next;
    logic           crc_fb;

    always_comb begin
        crc_fb   = crc_q[0] ^ tx_bit;
        crc_next = {1'b0, crc_q[7:1]} ^ (crc_fb ? 8'h8C : 8'h00);
    end

    assign crc_byte = crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 8'h00;
        else        crc_q <= crc_d;
    end
`else
    assign crc_byte = 8'h00;
`endif

    assign fall     = dq_prev_q & ~dq_s2_q;
    assign rise     = ~dq_prev_q & dq_s2_q;
    assign bus_rst  = (low_cnt_q == RST_LIM);
    assign slot_end = slot_act_q && (timer_q == T30_END);
    assign rx_byte  = {dq_s2_q, shift_q[7:1]};

    always_comb begin
        case (byte_cnt_q)
            4'd0:    tx_byte = temp_q[7:0];
            4'd1:    tx_byte = temp_q[15:8];
            4'd2:    tx_byte = 8'h4B;
            4'd3:    tx_byte = 8'h46;
            4'd4:    tx_byte = 8'h7F;
            4'd5:    tx_byte = 8'hFF;
            4'd6:    tx_byte = 8'h0C;
            4'd7:    tx_byte = 8'h10;
            default: tx_byte = crc_byte;
        endcase
        tx_bit = tx_byte[bit_cnt_q];
    end

    always_comb begin
        state_d      = state_q;
        low_cnt_d    = dq_s2_q ? '0 : (bus_rst ? low_cnt_q : low_cnt_q + 1'b1);
        timer_d      = slot_act_q ? timer_q + 1'b1 : timer_q;
        slot_act_d   = slot_act_q;
        drive_d      = drive_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        temp_d       = temp_q;
        cmd_byte_d   = cmd_byte_q;
        cmd_valid_d  = 1'b0;
        conv_start_d = 1'b0;
`ifdef DS18B20_CRC_EN
        crc_d        = crc_q;
`endif

        case (state_q)
            PRES_WAIT: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == T30_END) begin
                    state_d = PRES_DRIVE;
                    drive_d = 1'b1;
                    timer_d = '0;
                end
            end
            PRES_DRIVE: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == T120_END) begin
                    state_d = ROM_RX;
                    drive_d = 1'b0;
                end
            end
            ROM_RX, FUNC_RX: begin
                if (!slot_act_q && fall) begin
                    slot_act_d = 1'b1;
                    timer_d    = '0;
                end else if (slot_end) begin
                    slot_act_d = 1'b0;
                    shift_d    = rx_byte;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        cmd_valid_d = 1'b1;
                        cmd_byte_d  = rx_byte;
                        state_d     = DONE;
                        if (state_q == ROM_RX) begin
                            if (rx_byte == 8'hCC) state_d = FUNC_RX;
                        end else if (rx_byte == 8'h44) begin
                            temp_d       = temp_in;
                            conv_start_d = 1'b1;
                        end else if (rx_byte == 8'hBE) begin
                            state_d    = TX;
                            byte_cnt_d = 4'd0;
`ifdef DS18B20_CRC_EN
                            crc_d      = 8'h00;
`endif
                        end
                    end
                end
            end
            TX: begin
                // Our own drive never produces a fresh falling edge: the master already holds the bus low.
                if (!slot_act_q && fall) begin
                    slot_act_d = 1'b1;
                    timer_d    = '0;
                    drive_d    = ~tx_bit;
                end else if (slot_end) begin
                    slot_act_d = 1'b0;
                    drive_d    = 1'b0;
                    bit_cnt_d  = bit_cnt_q + 1'b1;
`ifdef DS18B20_CRC_EN
                    if (byte_cnt_q != 4'd8) crc_d = crc_next;
`endif
                    if (bit_cnt_q == 3'd7) begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        if (byte_cnt_q == 4'd8) state_d = DONE;
                    end
                end
            end
            default: ;
        endcase

        if (rise && bus_rst) begin
            state_d    = PRES_WAIT;
            timer_d    = '0;
            slot_act_d = 1'b0;
            drive_d    = 1'b0;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 4'd0;
        end else if (bus_rst) begin
            state_d    = IDLE;
            slot_act_d = 1'b0;
            drive_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_s1_q      <= 1'b1;
            dq_s2_q      <= 1'b1;
            dq_prev_q    <= 1'b1;
            state_q      <= IDLE;
            low_cnt_q    <= '0;
            timer_q      <= '0;
            slot_act_q   <= 1'b0;
            drive_q      <= 1'b0;
            shift_q      <= 8'h00;
            bit_cnt_q    <= 3'd0;
            byte_cnt_q   <= 4'd0;
            temp_q       <= 16'h0550;
            cmd_byte_q   <= 8'h00;
            cmd_valid_q  <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            dq_s1_q      <= dq_in;
            dq_s2_q      <= dq_s1_q;
            dq_prev_q    <= dq_s2_q;
            state_q      <= state_d;
            low_cnt_q    <= low_cnt_d;
            timer_q      <= timer_d;
            slot_act_q   <= slot_act_d;
            drive_q      <= drive_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            temp_q       <= temp_d;
            cmd_byte_q   <= cmd_byte_d;
            cmd_valid_q  <= cmd_valid_d;
            conv_start_q <= conv_start_d;
        end
    end

    assign dq_pull_low = drive_q;
    assign conv_start  = conv_start_q;
    assign cmd_valid   = cmd_valid_q;
    assign cmd_byte    = cmd_byte_q;

endmodule
